// File: rtl/wb_stage.sv
// wb_stage: writeback stage with byte-lane 32x32 register file and write-through reads.
// Define WB_DEBUG_TRACE_EN to add the debug_wb_* trace ports.
module wb_stage (
  input  logic        clk,
  input  logic        resetn,
  output logic        ws_allowin,
  input  logic        ms_to_ws_valid,
  input  logic [72:0] ms_to_ws_bus,
  input  logic [4:0]  rf_raddr1,
  input  logic [4:0]  rf_raddr2,
  output logic [31:0] rf_rdata1,
  output logic [31:0] rf_rdata2,
  output logic [41:0] ws_fwd_bus
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);
  logic        ws_valid_q, ws_valid_d;
  logic [72:0] bus_q, bus_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic        ws_ready_go;
  logic [3:0]  rf_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [31:0] pc;
  logic        wr_en;
  assign ws_ready_go = 1'b1;
  assign {rf_we, dest, result, pc} = bus_q;
  assign ws_allowin = !ws_valid_q || ws_ready_go;
  assign wr_en = ws_valid_q && (rf_we != 4'b0000) && (dest != 5'd0);
  always_comb begin
    ws_valid_d = ws_allowin ? ms_to_ws_valid : ws_valid_q;
    bus_d = (ms_to_ws_valid && ws_allowin) ? ms_to_ws_bus : bus_q;
    rf_d = rf_q;
    for (int i = 0; i < 4; i++)
      if (wr_en && rf_we[i]) rf_d[dest][8*i +: 8] = result[8*i +: 8];
    rf_d[0] = '0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      bus_q <= '0;
      rf_q <= '{default: '0};
    end else begin
      ws_valid_q <= ws_valid_d;
      bus_q <= bus_d;
      rf_q <= rf_d;
    end
  end
  // rf_d already holds the byte-merged value of the register being written
  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? '0 : rf_d[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? '0 : rf_d[rf_raddr2];
  assign ws_fwd_bus = {ws_valid_q, rf_we & {4{ws_valid_q}}, dest, result};
`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc = pc;
  assign debug_wb_rf_wen = rf_we & {4{ws_valid_q && (dest != 5'd0)}};
  assign debug_wb_rf_wnum = dest;
  assign debug_wb_rf_wdata = result;
`endif
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: resetn  input  1  async active-low reset.
REQ-004 SHALL have port: ws_allowin  output  1  stage can accept from mem stage.
REQ-005 SHALL have port: ms_to_ws_valid  input  1  mem stage offers instruction.
REQ-006 SHALL have port: ms_to_ws_bus  input  73  {rf_we[72:69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-007 SHALL have ports: rf_raddr1, rf_raddr2  input  5 each  decode read addresses.
REQ-008 SHALL have ports: rf_rdata1, rf_rdata2  output  32 each  decode read data.
REQ-009 SHALL have port: ws_fwd_bus  output  42  {ws_valid, rf_we[3:0], dest[4:0], final_result[31:0]} for decode bypass/interlock.
REQ-010 SHALL have, only under the configuration macro, ports debug_wb_pc (32), debug_wb_rf_wen (4), debug_wb_rf_wnum (5), debug_wb_rf_wdata (32), all outputs.

Function
REQ-011 SHALL hold a 1-bit ws_valid and a 73-bit bus register; ws_ready_go is constant 1.
REQ-012 SHALL drive ws_allowin = !ws_valid || ws_ready_go (always 1 out of reset).
REQ-013 SHALL load ws_valid <= ms_to_ws_valid on every edge where ws_allowin is 1.
REQ-014 SHALL capture ms_to_ws_bus into the bus register only when ms_to_ws_valid && ws_allowin; otherwise hold it.
REQ-015 SHALL contain a 32x32 register file; register 0 reads 0 and is never written.
REQ-016 SHALL write in the cycle ws_valid is 1: for each lane i with rf_we[i]=1, reg[dest][8i+7:8i] <= final_result[8i+7:8i]; lanes with rf_we[i]=0 keep old value.
REQ-017 SHALL suppress the write when ws_valid=0, rf_we=4'b0000 or dest=0.
REQ-018 SHALL return rf_rdataN combinationally; when raddrN equals a dest being written this cycle (REQ-016 active), SHALL return the byte-merged new value (write-through).
REQ-019 SHALL return 0 on rf_rdataN when raddrN=0, regardless of bypass.
REQ-020 SHALL drive ws_fwd_bus from the registered bus with its valid bit equal to ws_valid; rf_we field forced to 0 when ws_valid=0.
REQ-021 SHALL retire exactly one instruction per cycle with ws_valid=1; latency from capture edge to register-file update is one edge.
REQ-022 SHALL, for partial masks (e.g. 4'b1100 from LWL, 4'b0011 from LWR), preserve unselected bytes of the destination register.

Reset
REQ-023 SHALL, on resetn low, asynchronously clear ws_valid, the bus register and all 31 writable registers to 0.
REQ-024 SHALL drop any pending write when reset asserts mid-operation; no partial lane update.
REQ-025 SHALL, while in reset, drive ws_allowin=1, ws_fwd_bus=0, rf_rdata1/2=0, and all debug outputs 0.

Configuration
REQ-026 SHALL compile in debug trace ports only when WB_DEBUG_TRACE_EN is defined; without it the ports and logic are absent and behaviour is otherwise identical.
REQ-027 SHALL, with WB_DEBUG_TRACE_EN, drive debug_wb_pc=pc, debug_wb_rf_wen=rf_we gated by ws_valid (0 when dest=0), debug_wb_rf_wnum=dest, debug_wb_rf_wdata=final_result, all from the bus register.

Verification
REQ-028 SHALL test full write: valid bus rf_we=4'b1111, dest=5, result=0x12345678 -> next edge reg5=0x12345678, rf_rdata1(raddr1=5)=0x12345678.
REQ-029 SHALL test partial merge: reg7=0xAABBCCDD, rf_we=4'b1100, result=0x11220000 -> reg7=0x1122CCDD; rf_we=4'b0001, result=0x000000EE -> reg7=0x1122CCEE.
REQ-030 SHALL test write-through: writing reg3=0xDEADBEEF with raddr2=3 same cycle -> rf_rdata2=0xDEADBEEF before the edge.
REQ-031 SHALL test $0: rf_we=4'b1111, dest=0, result=0xFFFFFFFF -> rf_rdata1(raddr1=0)=0, debug_wb_rf_wen=0.
REQ-032 SHALL test bubble and reset: ms_to_ws_valid=0 for one cycle -> ws_fwd_bus valid bit 0, no write; resetn low mid-stream -> ws_valid=0 immediately, all registers read 0.
